uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side UART for the design's serial link. It decodes 8N1 frames from the `uart_rx_i` pin into bytes and presents each byte to the core on a valid/ready holding register. It is the counterpart of the design's `uart` transmitter and uses the same bit order, MSB first. It also reports framing errors and overruns.

## Interface
- `FREQ`, default 27000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `clk_i`  in  1  system clock; all logic on posedge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `uart_rx_i`  in  1  serial line, asynchronous to `clk_i`, idle high.
- `ready_i`  in  1  consumer accepts `data_o` in this cycle when `valid_o` is high.
- `valid_o`  out  1  `data_o` holds an unread byte.
- `data_o`  out  8  received byte.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun_o`  out  1  one-cycle pulse: an unread byte was overwritten.

## Operation
- Constants:
  - `BIT_CYCLES = FREQ/BAUD + 1`, which is 235 at the defaults and matches the TX bit period.
  - `HALF_CYCLES = BIT_CYCLES/2`, using integer division.
  - The bit counter is 24 bits wide, counts down, and reloads on zero.
- Synchronizer: two flops on `uart_rx_i`, both reset to 1. All decoding uses the synchronized signal `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK. The reset state is IDLE.
- IDLE:
  - When `rx_s`=0, go to START and set cnt=HALF_CYCLES-1.
- START (sample when cnt=0):
  - If `rx_s`=1, it was a glitch. Go back to IDLE with no output.
  - Otherwise set cnt=BIT_CYCLES-1 and bit_idx=0, then go to DATA.
- DATA (sample when cnt=0):
  - Shift in with shift <= {shift[6:0], rx_s}, so the first data bit lands in bit 7.
  - Increment bit_idx (3 bits) and reload cnt.
  - After the 8th sample, go to STOP.
- STOP (sample when cnt=0):
  - If `rx_s`=1, commit the shift register to `data_o`, set `valid_o`=1, and go to IDLE.
  - If `rx_s`=0, pulse `frame_err_o`, leave `data_o` and `valid_o` unchanged, and go to BREAK.
- BREAK:
  - Stay until `rx_s`=1, then go to IDLE. A held-low line produces exactly one `frame_err_o`.
- Output register:
  - `valid_o` clears on a cycle where `valid_o` & `ready_i` are both high, unless a commit occurs in the same cycle.
  - Commit while `valid_o`=1 and `ready_i`=0: overwrite `data_o`, keep `valid_o`=1, pulse `overrun_o`.
  - Commit in the same cycle as a handshake: new data, `valid_o` stays 1, no overrun.
  - `ready_i` has no effect while `valid_o`=0.
- Reset (asynchronous, any time, including mid-frame):
  - FSM=IDLE, cnt=0, bit_idx=0, shift=0, synchronizer flops=1.
  - Outputs: `data_o`=0, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0.
  - A partial frame is dropped. If the line is low when reset is released, the receiver treats it as a start bit.

## Timing
- Let t0 be the first clock edge at which `rx_s`=0 is seen in IDLE. This is 2–3 cycles after the pin falls.
- Sample k (k=0 for start, 1..8 for data, 9 for stop) is taken at t0 + HALF_CYCLES + k·BIT_CYCLES.
- `valid_o`, `frame_err_o` and `overrun_o` change on the edge that takes sample 9, so they are visible in the following cycle.
- The receiver returns to IDLE at sample 9 and accepts a new start bit one cycle later. This allows back-to-back frames with no idle time and tolerates about ±4% baud mismatch.
- Sample 9 occurs mid-stop bit, so the receiver is re-armed half a bit before the transmitter finishes the stop bit.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [2:0]` for the FSM states (rx_state_t).
  - Function `bit_cycles(FREQ, BAUD)`. The same function is used by the TX so both ends agree on the bit period.
- Sub-module `sync2`: generic two-flop synchronizer with a reset value parameter (default 1). Reusable for other asynchronous inputs.
- Everything else lives in a single `always_ff` for the FSM and datapath plus the output register.

## Test plan
Bench settings: FREQ=1265000, BAUD=115200, giving BIT_CYCLES=11 and HALF_CYCLES=5. Drive the pin at 11 cycles per bit.
- Frame 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1), `ready_i`=1 → one `valid_o` cycle with `data_o`=0xA5, asserted 5+9·11+1 cycles after t0; no error pulses.
- 1-bit-time... correction: a 3-cycle low glitch on an idle line → FSM returns to IDLE; no `valid_o`, no `frame_err_o`.
- Frame 0x3C with stop bit low, then the line held low for 40 cycles → exactly one `frame_err_o` pulse; `valid_o` stays 0; a following 0x81 frame is received correctly.
- Back-to-back 0x12 then 0x34 with `ready_i`=0 → after frame 1, `valid_o`=1 and `data_o`=0x12; after frame 2, one `overrun_o` pulse and `data_o`=0x34; raising `ready_i` for 1 cycle clears `valid_o`.
- `ready_i` pulsed on exactly the commit cycle of a second frame (0x55) → `valid_o` stays 1, `data_o`=0x55, no `overrun_o`.
- `rstn_i` asserted during data bit 4 of frame 0xFF, then released with the line high → all outputs 0; the next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the bit-period helper
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  function automatic int unsigned bit_cycles(input int unsigned freq,
                                             input int unsigned baud);
    return freq / baud + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, MSB first, with a valid/ready holding register and
// framing-error / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ = 27000000,
  parameter int unsigned BAUD = 115200
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       uart_rx_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned BIT_CYCLES  = bit_cycles(FREQ, BAUD);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam logic [23:0] BIT_RELOAD  = 24'(BIT_CYCLES - 1);
  localparam logic [23:0] HALF_RELOAD = 24'(HALF_CYCLES - 1);

  logic        rx_s;
  rx_state_t   state, state_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n, ovr_n;
  logic        tick, commit;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (uart_rx_i),
    .q_o    (rx_s)
  );

  assign tick = (cnt == '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_n    = data_o;
    valid_n   = valid_o;
    ferr_n    = 1'b0;
    ovr_n     = 1'b0;
    commit    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_START;
          cnt_n   = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (!tick) begin
          cnt_n = cnt - 24'd1;
        end else if (rx_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n   = ST_DATA;
          cnt_n     = BIT_RELOAD;
          bit_idx_n = '0;
        end
      end
      ST_DATA: begin
        if (!tick) begin
          cnt_n = cnt - 24'd1;
        end else begin
          shift_n   = {shift[6:0], rx_s};
          bit_idx_n = bit_idx + 3'd1;
          cnt_n     = BIT_RELOAD;
          if (bit_idx == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick) begin
          cnt_n = cnt - 24'd1;
        end else if (rx_s) begin
          commit  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A commit wins over a same-cycle handshake; it only overruns when unread.
    if (commit) begin
      data_n  = shift;
      valid_n = 1'b1;
      ovr_n   = valid_o & ~ready_i;
    end else if (valid_o && ready_i) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_o      <= data_n;
      valid_o     <= valid_n;
      frame_err_o <= ferr_n;
      overrun_o   <= ovr_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 11 clocks per bit (FREQ=1265000, BAUD=115200).
module tb_uart_rx;

  localparam int unsigned BIT = 11;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pin;
  logic       ready;
  logic       valid_o;
  logic [7:0] data_o;
  logic       frame_err_o;
  logic       overrun_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  int n_valid_hi = 0, n_valid_rise = 0, n_ferr = 0, n_ovr = 0;
  int rise_cyc = 0;
  logic [7:0] rise_data = '0;
  logic valid_q = 1'b0;
  int s_hi, s_rise, s_ferr, s_ovr;
  int fall_cyc = 0;

  uart_rx #(.FREQ(1265000), .BAUD(115200)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .uart_rx_i   (pin),
    .ready_i     (ready),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_o) n_valid_hi++;
    if (valid_o && !valid_q) begin
      n_valid_rise++;
      rise_cyc  = cyc;
      rise_data = data_o;
    end
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
    valid_q = valid_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_hi = n_valid_hi; s_rise = n_valid_rise; s_ferr = n_ferr; s_ovr = n_ovr;
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {1'b0, b, stop_bit};
    fall_cyc = cyc;
    for (int i = 9; i >= 0; i--) begin
      pin = frame[i];
      wait_cycles(BIT);
    end
  endtask

  initial begin
    rstn = 1'b0; pin = 1'b1; ready = 1'b0;
    wait_cycles(3);
    rstn = 1'b1;
    wait_cycles(3);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);

    // 0xA5 with ready held high; valid lands 3 + 5 + 9*11 edges after the fall
    snap(); ready = 1'b1;
    send_byte(8'hA5, 1'b1);
    wait_cycles(5);
    check("a5_rises", 32'(n_valid_rise - s_rise), 32'd1);
    check("a5_hi_cycles", 32'(n_valid_hi - s_hi), 32'd1);
    check("a5_data", 32'(rise_data), 32'hA5);
    check("a5_latency", 32'(rise_cyc - fall_cyc), 32'd107);
    check("a5_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("a5_ovr", 32'(n_ovr - s_ovr), 32'd0);

    // 3-cycle glitch
    snap();
    pin = 1'b0; wait_cycles(3); pin = 1'b1;
    wait_cycles(30);
    check("glitch_valid", 32'(n_valid_hi - s_hi), 32'd0);
    check("glitch_ferr", 32'(n_ferr - s_ferr), 32'd0);

    // bad stop bit then break, then recovery with 0x81
    snap();
    send_byte(8'h3C, 1'b0);
    wait_cycles(40);
    pin = 1'b1;
    wait_cycles(BIT);
    check("brk_ferr", 32'(n_ferr - s_ferr), 32'd1);
    check("brk_valid", 32'(n_valid_hi - s_hi), 32'd0);
    snap();
    send_byte(8'h81, 1'b1);
    wait_cycles(5);
    check("r81_rises", 32'(n_valid_rise - s_rise), 32'd1);
    check("r81_data", 32'(rise_data), 32'h81);
    check("r81_ferr", 32'(n_ferr - s_ferr), 32'd0);

    // back-to-back frames into an unread register
    ready = 1'b0; snap();
    send_byte(8'h12, 1'b1);
    check("b2b1_valid", 32'(valid_o), 32'd1);
    check("b2b1_data", 32'(data_o), 32'h12);
    check("b2b1_ovr", 32'(n_ovr - s_ovr), 32'd0);
    send_byte(8'h34, 1'b1);
    check("b2b2_valid", 32'(valid_o), 32'd1);
    check("b2b2_data", 32'(data_o), 32'h34);
    check("b2b2_ovr", 32'(n_ovr - s_ovr), 32'd1);
    ready = 1'b1; wait_cycles(1); ready = 1'b0;
    wait_cycles(1);
    check("b2b_clear", 32'(valid_o), 32'd0);

    // handshake on the exact commit edge of the second frame
    send_byte(8'h11, 1'b1);
    check("hs1_valid", 32'(valid_o), 32'd1);
    snap();
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (106) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    check("hs2_valid", 32'(valid_o), 32'd1);
    check("hs2_data", 32'(data_o), 32'h55);
    check("hs2_ovr", 32'(n_ovr - s_ovr), 32'd0);
    ready = 1'b1; wait_cycles(1); ready = 1'b0;
    wait_cycles(1);
    check("hs_clear", 32'(valid_o), 32'd0);

    // reset during data bit 4 of 0xFF
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (47) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_data", 32'(data_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
      end
    join
    wait_cycles(5);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    check("post_rst_data", 32'(data_o), 32'd0);
    snap(); ready = 1'b1;
    send_byte(8'h0F, 1'b1);
    wait_cycles(5);
    check("r0f_rises", 32'(n_valid_rise - s_rise), 32'd1);
    check("r0f_data", 32'(rise_data), 32'h0F);
    check("r0f_ferr", 32'(n_ferr - s_ferr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
